// File: rtl/regwrite_scheduler_if.sv
// Bundle of every non-clock signal of regwrite_scheduler.
// The slave modport is the scheduler's view; the master modport is the view of
// the surrounding pipeline / long-latency unit / register file.
// Optional macro REGWRITE_SCHED_BYPASS_EN adds the decode bypass signals.
//
// Handshake: a long-latency result transfers on a rising clk edge where
// b_valid && b_ready are both high; b_valid may not depend on b_ready, and
// b_ready depends only on registered buffer occupancy.
interface regwrite_scheduler_if #(
    parameter int WAD = 5,
    parameter int WD  = 32
);
    logic           regwriteW;
    logic [WAD-1:0] rdW;
    logic [WD-1:0]  resultW;
    logic           issue_valid;
    logic [WAD-1:0] issue_rd;
    logic           b_valid;
    logic [WAD-1:0] b_rd;
    logic [WD-1:0]  b_data;
    logic           b_ready;
    logic [WAD-1:0] rs1D;
    logic [WAD-1:0] rs2D;
    logic [WAD-1:0] rdD;
    logic           stallD;
    logic           starve_hold;
    logic           we;
    logic [WAD-1:0] waddr;
    logic [WD-1:0]  wdata;
    logic           sb_err;
`ifdef REGWRITE_SCHED_BYPASS_EN
    logic           byp1_en;
    logic           byp2_en;
    logic [WD-1:0]  byp_data;
`endif

    modport slave (
        input  regwriteW, rdW, resultW,
        input  issue_valid, issue_rd,
        input  b_valid, b_rd, b_data,
        output b_ready,
        input  rs1D, rs2D, rdD,
        output stallD, starve_hold,
        output we, waddr, wdata,
`ifdef REGWRITE_SCHED_BYPASS_EN
        output byp1_en, byp2_en, byp_data,
`endif
        output sb_err
    );

    modport master (
        output regwriteW, rdW, resultW,
        output issue_valid, issue_rd,
        output b_valid, b_rd, b_data,
        input  b_ready,
        output rs1D, rs2D, rdD,
        input  stallD, starve_hold,
        input  we, waddr, wdata,
`ifdef REGWRITE_SCHED_BYPASS_EN
        input  byp1_en, byp2_en, byp_data,
`endif
        input  sb_err
    );
endinterface

// File: rtl/regwrite_scheduler.sv
// regwrite_scheduler: owns the register-file write port. The in-order pipeline
// writeback always wins; long-latency results wait in a small FIFO and drain
// whenever the pipeline leaves the port free. A per-register pending scoreboard
// tracks outstanding long-latency destinations and stalls decode on hazards.
// Optional macro REGWRITE_SCHED_BYPASS_EN: decode may consume the result that
// is committing this cycle (byp1_en/byp2_en/byp_data) instead of stalling.
module regwrite_scheduler #(
    parameter int WAD        = 5,
    parameter int WD         = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regwrite_scheduler_if.slave  bus
);
    localparam int NREG = 2 ** WAD;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int SW   = $clog2(STARVE_MAX + 1);

    // Result buffer storage (data path only, no reset needed)
    logic [WAD-1:0] rd_mem_q   [DEPTH];
    logic [WD-1:0]  data_mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic            err_q, err_d;
    logic [SW-1:0]   starve_q, starve_d;

    logic            pipe_wr;
    logic            empty;
    logic            full;
    logic            push;
    logic            accept;
    logic            pop;
    logic [WAD-1:0]  head_rd;
    logic [WD-1:0]   head_data;
    logic            we_w;
    logic [WAD-1:0]  waddr_w;
    logic [WD-1:0]   wdata_w;
    logic [NREG-1:0] pend_vis;

    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    // A result for x0 is still handshaken but never occupies an entry.
    assign accept    = bus.b_valid && !full;
    assign push      = accept && (bus.b_rd != '0);
    // Writes to x0 never reach the port.
    assign pipe_wr   = bus.regwriteW && (bus.rdW != '0);
    // The buffer head commits only when the pipeline leaves the port idle.
    assign pop       = !pipe_wr && !empty;

    // Write-port arbitration: pipeline first, then buffer head; quiet in reset.
    always_comb begin
        we_w    = 1'b0;
        waddr_w = '0;
        wdata_w = '0;
        if (!rst) begin
            if (pipe_wr) begin
                we_w    = 1'b1;
                waddr_w = bus.rdW;
                wdata_w = bus.resultW;
            end else if (!empty) begin
                we_w    = 1'b1;
                waddr_w = head_rd;
                wdata_w = head_data;
            end
        end
    end

    assign bus.we      = we_w;
    assign bus.waddr   = waddr_w;
    assign bus.wdata   = wdata_w;
    assign bus.b_ready = !full;

    // Buffer pointers and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Scoreboard: clear on head commit, set on issue (set applied last so it wins).
    always_comb begin
        pend_d = pend_q;
        if (pop) begin
            pend_d[head_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            pend_d[bus.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
        err_d = err_q | (bus.issue_valid && (bus.issue_rd != '0) && pend_q[bus.issue_rd]);
    end

    // Starvation counter: counts cycles the pipeline holds the port over a waiting result.
    always_comb begin
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Decode hazard view of the scoreboard; with bypass, the committing rd is visible.
    always_comb begin
        pend_vis = pend_q;
`ifdef REGWRITE_SCHED_BYPASS_EN
        if (pop) begin
            pend_vis[head_rd] = 1'b0;
        end
`endif
    end

    assign bus.stallD      = pend_vis[bus.rs1D] | pend_vis[bus.rs2D] | pend_vis[bus.rdD];
    assign bus.starve_hold = (starve_q == SW'(STARVE_MAX));
    assign bus.sb_err      = err_q;

`ifdef REGWRITE_SCHED_BYPASS_EN
    // head_rd is never x0, so a zero source address never bypasses.
    assign bus.byp1_en  = pop && (bus.rs1D == head_rd);
    assign bus.byp2_en  = pop && (bus.rs2D == head_rd);
    assign bus.byp_data = wdata_w;
`endif

    // Control state registers; reset discards buffer contents and pending bits at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    // Buffer payload write on accepted, non-x0 results.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= bus.b_rd;
            data_mem_q[wr_ptr_q] <= bus.b_data;
        end
    end

endmodule

// File: doc/regwrite_scheduler.md
Name: regwrite_scheduler

Overview:
- Owns the single register-file write port and arbitrates it between the in-order pipeline writeback and a long-latency unit (divider / slow load return).
- Keeps a per-register pending scoreboard for long-latency destinations and raises a decode stall on RAW/WAW hazards against them.
- Sits between the W stage, the long-latency unit and the register file write inputs; the hazard unit consumes its stall outputs.

Parameters:
- WAD, 5, register address width (2**WAD registers).
- WD, 32, data width.
- DEPTH, 2, long-latency result buffer depth (power of 2, >=2).
- STARVE_MAX, 8, consecutive blocked cycles before starve_hold asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- regwriteW  in  1  pipeline writeback request.
- rdW  in  WAD  pipeline destination.
- resultW  in  WD  pipeline write data.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  WAD  its destination.
- b_valid  in  1  long-latency result valid.
- b_rd  in  WAD  result destination.
- b_data  in  WD  result data.
- b_ready  out  1  buffer can accept.
- rs1D, rs2D, rdD  in  WAD  decode-stage operand/destination addresses.
- stallD  out  1  decode must stall.
- starve_hold  out  1  request hazard unit to inject a W-stage bubble.
- we  out  1  register file write enable.
- waddr  out  WAD  register file write address.
- wdata  out  WD  register file write data.
- sb_err  out  1  sticky scoreboard error.

Behaviour:
- Reset: scoreboard all 0, buffer empty, starve counter 0, sb_err 0; outputs b_ready=1, stallD=0, starve_hold=0, we=0.
- Port arbitration (combinational): regwriteW && rdW!=0 has absolute priority -> we=1, waddr=rdW, wdata=resultW. Otherwise, if the buffer is non-empty -> we=1 with the buffer head; the head pops at the clock edge. Otherwise we=0. Writes to x0 are never issued on the port.
- Buffer: FIFO of {rd,data}, DEPTH entries. Push on b_valid && b_ready. b_ready = !full. Pushing while full never occurs. Simultaneous push and pop when full is not allowed: b_ready stays low when full. Push with b_rd==0 is accepted and discarded (no entry). Minimum accept-to-write latency is 1 cycle. Pointers wrap modulo DEPTH.
- Scoreboard: one bit per register; bit 0 is hardwired 0.
  - Set at the edge when issue_valid && issue_rd!=0.
  - Clear at the edge when a buffer head commits to the port for that rd.
  - If set and clear target the same rd in one cycle, set wins.
  - issue_valid to an already-pending rd sets sb_err (sticky until reset); the bit stays set.
- stallD = pending[rs1D] | pending[rs2D] | pending[rdD]. Registered state only; it deasserts the cycle after the committing edge.
- Starvation counter:
  - Increments each cycle the buffer is non-empty and the port is taken by the pipeline.
  - Resets to 0 on any buffer commit or when the buffer is empty.
  - Saturates at STARVE_MAX.
  - starve_hold = (count==STARVE_MAX).
- Reset mid-operation: buffered results and pending bits are discarded immediately (asynchronous).

Optional Feature:
- Macro REGWRITE_SCHED_BYPASS_EN.
- Defined: the compare for stallD excludes a pending bit whose rd equals the buffer head being committed this cycle. Adds outputs byp1_en/byp2_en (1 bit each) that assert when rs1D/rs2D match that committing rd, with byp_data=wdata. Decode proceeds the same cycle.
- Undefined: no bypass ports; stallD holds until the cycle after commit.

Test Plan:
- Reset, then regwriteW=1, rdW=3, resultW=0x11 -> same cycle we=1, waddr=3, wdata=0x11. rdW=0 with regwriteW=1 -> we=0.
- issue_valid, issue_rd=7; next cycle rs1D=7 -> stallD=1. b_valid, b_rd=7, b_data=0xABCD with the port idle -> accepted; next cycle we=1, waddr=7, wdata=0xABCD; the cycle after, stallD=0.
- Pipeline writes every cycle while 2 B results arrive -> b_ready=0 after two pushes. After 8 blocked cycles starve_hold=1. Drop regwriteW one cycle -> head commits, counter returns to 0, starve_hold=0.
- Same cycle: issue_rd=5 and buffer head with rd=5 commits -> pending[5] remains 1. Issue rd=5 again while pending -> sb_err=1 until rst.
- Assert rst mid-drain with the buffer holding 2 entries -> we=0, b_ready=1 and stallD=0 immediately, without waiting for a clock edge.
- With REGWRITE_SCHED_BYPASS_EN, head rd=9 commits while rs2D=9 -> stallD=0, byp2_en=1, byp_data equals the head data.
